// File: rtl/ula_pkg.sv
// Shared types and constants for the ula_8_bits multiply sequencer.
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam logic [3:0]  ULA_S_ADD    = 4'b1001;
    localparam logic        ULA_M_ARITH  = 1'b0;
    localparam logic        ULA_CIN_NONE = 1'b1;
    localparam int unsigned MUL_STEPS    = 8;

endpackage

// File: rtl/ula_8_bits.sv
// 8-bit 74181-style ALU, active-high data; c_in and c_out are active-low carries.
module ula_8_bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       c_out,
    output logic       a_eq_b,
    output logic       overflow
);

    logic [7:0] x;
    logic [7:0] y;
    logic [8:0] sum;

    // Arithmetic result is X plus Y plus carry; logic result is ~(X ^ Y).
    always_comb begin
        x   = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
        y   = (a & b & {8{s[3]}}) | (a & ~b & {8{s[2]}});
        sum = {1'b0, x} + {1'b0, y} + {8'b0, ~c_in};
        if (m) begin
            f        = ~(x ^ y);
            c_out    = 1'b1;
            overflow = 1'b0;
        end else begin
            f        = sum[7:0];
            c_out    = ~sum[8];
            overflow = (x[7] == y[7]) && (sum[7] != x[7]);
        end
        a_eq_b = &f;
    end

endmodule

// File: rtl/ula_mul_seq.sv
// Shift-and-add 8x8 unsigned multiplier sequencing one ula_8_bits instance.
// Optional early exit when the remaining multiplier bits are zero: ULA_MUL_EARLY_EXIT_EN.
module ula_mul_seq
    import ula_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);

    mul_state_t  state;
    mul_state_t  state_next;
    logic [7:0]  acc;
    logic [7:0]  mq;
    logic [7:0]  mcand;
    logic [3:0]  cnt;
    logic [15:0] prod_q;
    logic [7:0]  alu_f;
    logic        alu_c_out;
    logic        carry;
    logic [15:0] step_p;
    logic        last_step;
    logic        early_exit;
    logic [15:0] early_p;

    ula_8_bits u_alu (
        .a        (acc),
        .b        (mcand),
        .s        (ULA_S_ADD),
        .m        (ULA_M_ARITH),
        .c_in     (ULA_CIN_NONE),
        .f        (alu_f),
        .c_out    (alu_c_out),
        .a_eq_b   (),
        .overflow ()
    );

    assign carry     = ~alu_c_out;
    assign last_step = (cnt == 4'(MUL_STEPS - 1));

    always_comb begin
        if (mq[0]) step_p = {carry, alu_f, mq[7:1]};
        else       step_p = {1'b0, acc, mq[7:1]};
    end

`ifdef ULA_MUL_EARLY_EXIT_EN
    logic [7:0] mrem;

    // Remaining steps would only shift zeros in, so apply them as one shift.
    assign early_exit = (mrem == 8'd0);
    assign early_p    = {acc, mq} >> (4'(MUL_STEPS) - cnt);

    always_ff @(posedge clk) begin
        if (!rst_n)                        mrem <= '0;
        else if (state == IDLE && in_valid) mrem <= b;
        else if (state == RUN)             mrem <= mrem >> 1;
    end
`else
    assign early_exit = 1'b0;
    assign early_p    = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (early_exit || last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mq     <= '0;
            mcand  <= '0;
            cnt    <= '0;
            prod_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= '0;
                        mq    <= b;
                        mcand <= a;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (early_exit) begin
                        prod_q <= early_p;
                    end else begin
                        {acc, mq} <= step_p;
                        cnt       <= cnt + 4'd1;
                        if (last_step) prod_q <= step_p;
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = prod_q;

endmodule
